// File: rtl/id_ex_skid_reg.sv
// rtl/id_ex_skid_reg.sv - ID/EX pipeline register with valid/ready handshake, one-entry skid and flush
//
// Purpose: carries one decoded instruction payload from decode (id) to
// execute (ex). A main register drives the outputs; a skid register absorbs
// one extra payload so that in_ready_o can be a registered signal while the
// stage still sustains one payload per cycle. flush_i discards everything.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush_i                         synchronous flush (highest priority)
//   in_valid_i / in_ready_o         handshake with id (in_ready_o registered)
//   inst_i, inst_addr_i, op1_i,
//   op2_i, rd_addr_i, reg_wen_i     payload from id
//   out_valid_o / out_ready_i       handshake with ex
//   inst_o, inst_addr_o, op1_o,
//   op2_o, rd_addr_o, reg_wen_o     payload to ex (bubble when not valid)

module id_ex_skid_reg #(
  parameter int                XLEN     = 32,
  parameter int                RADDR_W  = 5,
  parameter logic [XLEN-1:0]   NOP_INST = XLEN'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [XLEN-1:0]    inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  input  logic               reg_wen_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    inst_o,
  output logic [XLEN-1:0]    inst_addr_o,
  output logic [XLEN-1:0]    op1_o,
  output logic [XLEN-1:0]    op2_o,
  output logic [RADDR_W-1:0] rd_addr_o,
  output logic               reg_wen_o
);

  localparam int PW = 4 * XLEN + RADDR_W + 1;

  // addi x0,x0,0 with every other field zero; reg_wen=0 keeps ex from writing.
  localparam logic [PW-1:0] BUBBLE = {NOP_INST, {(3 * XLEN + RADDR_W + 1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic [PW-1:0] in_pl;
  logic          acc;
  logic          drn;

  assign in_pl       = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = in_ready_q;
  assign acc         = in_valid_i & in_ready_q;
  assign drn         = out_valid_o & out_ready_i;

  // Main always holds the bubble when empty, so the outputs need no masking.
  assign {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = in_pl;
            state_d = ONE;
          end
        end
        ONE: begin
          if (drn && acc) begin
            main_d = in_pl;
          end else if (drn) begin
            main_d  = BUBBLE;
            state_d = EMPTY;
          end else if (acc) begin
            skid_d  = in_pl;
            state_d = FULL;
          end
        end
        FULL: begin
          // in_ready_o is low here, so nothing can be accepted this cycle.
          if (drn) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // in_ready is a flop fed by the next-state decode, so ex's out_ready_i never
  // reaches in_ready_o combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// tb/tb_id_ex_skid_reg.sv - scoreboard bench for id_ex_skid_reg at XLEN=32 and XLEN=64
module tb_id_ex_skid_reg;

  typedef struct packed {
    logic [63:0] inst;
    logic [63:0] addr;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [5:0]  rd;
    logic        wen;
  } pl_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic ordy;
  pl_t  din;

  logic        ir32, ov32, wen32;
  logic [31:0] inst32, addr32, op1_32, op2_32;
  logic [4:0]  rd32;
  logic        ir64, ov64, wen64;
  logic [63:0] inst64, addr64, op1_64, op2_64;
  logic [5:0]  rd64;

  pl_t q32[$];
  pl_t q64[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  id_ex_skid_reg dut32 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir32),
    .inst_i(din.inst[31:0]), .inst_addr_i(din.addr[31:0]),
    .op1_i(din.op1[31:0]), .op2_i(din.op2[31:0]),
    .rd_addr_i(din.rd[4:0]), .reg_wen_i(din.wen),
    .out_valid_o(ov32), .out_ready_i(ordy),
    .inst_o(inst32), .inst_addr_o(addr32), .op1_o(op1_32), .op2_o(op2_32),
    .rd_addr_o(rd32), .reg_wen_o(wen32)
  );

  id_ex_skid_reg #(.XLEN(64), .RADDR_W(6)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(ir64),
    .inst_i(din.inst), .inst_addr_i(din.addr),
    .op1_i(din.op1), .op2_i(din.op2),
    .rd_addr_i(din.rd), .reg_wen_i(din.wen),
    .out_valid_o(ov64), .out_ready_i(ordy),
    .inst_o(inst64), .inst_addr_o(addr64), .op1_o(op1_64), .op2_o(op2_64),
    .rd_addr_o(rd64), .reg_wen_o(wen64)
  );

  function automatic pl_t mk(logic [63:0] i, logic [63:0] a, logic [63:0] o1,
                             logic [63:0] o2, logic [5:0] r, logic w);
    pl_t p;
    p.inst = i; p.addr = a; p.op1 = o1; p.op2 = o2; p.rd = r; p.wen = w;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, driven at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic v, input pl_t p, input logic r, input logic f);
    in_valid = v;
    din      = p;
    ordy     = r;
    flush    = f;
    if (f) begin
      q32.delete();
      q64.delete();
    end else begin
      if (v && ir32) q32.push_back(p);
      if (v && ir64) q64.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, '0, r, 1'b0);
  endtask

  // Monitors: every output handshake pops and compares one expected payload.
  always @(negedge clk) begin
    if (rst_n && ov32 && ordy) begin
      total++;
      if (q32.size() == 0) begin
        bad++;
        $display("FAIL mon32_unexpected actual_inst=%h required=none", inst32);
      end else begin
        pl_t e;
        e = q32.pop_front();
        if ({inst32, addr32, op1_32, op2_32, rd32, wen32} !==
            {e.inst[31:0], e.addr[31:0], e.op1[31:0], e.op2[31:0], e.rd[4:0], e.wen}) begin
          bad++;
          $display("FAIL mon32_payload actual=%h required=%h",
                   {inst32, addr32, op1_32, op2_32, rd32, wen32},
                   {e.inst[31:0], e.addr[31:0], e.op1[31:0], e.op2[31:0], e.rd[4:0], e.wen});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov64 && ordy) begin
      total++;
      if (q64.size() == 0) begin
        bad++;
        $display("FAIL mon64_unexpected actual_inst=%h required=none", inst64);
      end else begin
        pl_t e;
        e = q64.pop_front();
        if ({inst64, addr64, op1_64, op2_64, rd64, wen64} !== e) begin
          bad++;
          $display("FAIL mon64_payload actual=%h required=%h",
                   {inst64, addr64, op1_64, op2_64, rd64, wen64}, e);
        end
      end
    end
  end

  pl_t pa, pb, pc;

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    ordy     = 1'b0;
    din      = '0;

    // Reset state
    #12;
    chk("rst_valid32", 64'(ov32), 64'd0);
    chk("rst_ready32", 64'(ir32), 64'd1);
    chk("rst_inst32", 64'(inst32), 64'h13);
    chk("rst_inst64", inst64, 64'h13);
    chk("rst_rest32", {addr32, op1_32}, 64'd0);
    chk("rst_wen64", {57'd0, rd64, wen64}, 64'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: 16 payloads back to back, each visible one cycle later
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, mk(64'h100 + 64'(i), 64'(4 * i), 64'hDEAD_BEEF_0000_0001 + 64'(i),
                   {32'(i), 32'hCAFE_F00D}, 6'(i + 20), i[0]), 1'b1, 1'b0);
      chk("stream_inst32", 64'(inst32), 64'h100 + 64'(i));
      chk("stream_valid32", 64'(ov32), 64'd1);
      chk("stream_op1_64", op1_64, 64'hDEAD_BEEF_0000_0001 + 64'(i));
    end
    idle(1'b1);
    chk("stream_end_valid", 64'(ov32), 64'd0);

    // Backpressure: A, B, C with ex stalled the cycle after A is accepted
    pa = mk(64'hA00, 64'h40, 64'hDEAD_BEEF_0000_0001, 64'h1, 6'h21, 1'b1);
    pb = mk(64'hB00, 64'h44, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 6'h02, 1'b0);
    pc = mk(64'hC00, 64'h48, 64'h8000_0000_0000_0000, 64'h3, 6'h3F, 1'b1);
    cyc(1'b1, pa, 1'b1, 1'b0);
    cyc(1'b1, pb, 1'b0, 1'b0);
    chk("bp_ready_full32", 64'(ir32), 64'd0);
    chk("bp_ready_full64", 64'(ir64), 64'd0);
    chk("bp_hold_a", 64'(inst32), 64'hA00);
    cyc(1'b1, pc, 1'b0, 1'b0);
    chk("bp_stable_a", inst64, 64'hA00);
    chk("bp_stable_op1", op1_64, 64'hDEAD_BEEF_0000_0001);
    cyc(1'b1, pc, 1'b1, 1'b0);
    chk("bp_b_out", 64'(inst32), 64'hB00);
    chk("bp_ready_back", 64'(ir32), 64'd1);
    cyc(1'b1, pc, 1'b1, 1'b0);
    chk("bp_c_out", inst64, 64'hC00);
    idle(1'b1);
    chk("bp_empty", 64'(ov64), 64'd0);

    // Flush in FULL with C presented: nothing survives
    cyc(1'b1, pa, 1'b0, 1'b0);
    cyc(1'b1, pb, 1'b0, 1'b0);
    chk("fl_full", 64'(ir32), 64'd0);
    cyc(1'b1, pc, 1'b0, 1'b1);
    flush = 1'b0;
    chk("fl_valid", 64'(ov32), 64'd0);
    chk("fl_inst", 64'(inst32), 64'h13);
    chk("fl_ready", 64'(ir32), 64'd1);
    chk("fl_wen64", 64'(wen64), 64'd0);
    idle(1'b1);
    chk("fl_still_empty", 64'(ov64), 64'd0);

    // Drain to bubble
    cyc(1'b1, mk(64'h0070_0093, 64'h80, 64'h5, 64'h6, 6'd7, 1'b1), 1'b1, 1'b0);
    chk("db_wen_on", 64'(wen32), 64'd1);
    chk("db_rd_on", 64'(rd32), 64'd7);
    idle(1'b1);
    chk("db_wen_off", 64'(wen32), 64'd0);
    chk("db_rd_off", 64'(rd32), 64'd0);
    chk("db_inst_nop", 64'(inst32), 64'h13);
    chk("db_valid", 64'(ov32), 64'd0);

    // Asynchronous reset in the middle of a FULL cycle
    cyc(1'b1, pa, 1'b0, 1'b0);
    cyc(1'b1, pb, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q32.delete();
    q64.delete();
    chk("ar_valid", 64'(ov32), 64'd0);
    chk("ar_ready", 64'(ir64), 64'd1);
    chk("ar_inst64", inst64, 64'h13);
    chk("ar_op1_64", op1_64, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(1'b1);
    chk("ar_after_valid", 64'(ov64), 64'd0);

    chk("sb32_left", 64'(q32.size()), 64'd0);
    chk("sb64_left", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised ID/EX pipeline register for the RISC-V core with valid/ready handshake, a one-entry skid buffer and a synchronous flush. It sits between the decode stage (id) and the execute stage (ex). It carries the same payload as the plain ID/EX register: instruction, instruction address, two operands, destination address and write enable. It adds stall tolerance at full throughput and bubble insertion on branch/jump flush.

## Interface
- XLEN, 32, width of inst, inst_addr, op1, op2
- RADDR_W, 5, width of rd_addr
- NOP_INST, 32'h0000_0013, instruction value presented whenever no valid entry is on the output (addi x0,x0,0)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous flush; discards all held entries and the current input
- in_valid_i  in  1  id presents a valid payload
- in_ready_o  out  1  block can accept a payload this cycle (registered)
- inst_i, inst_addr_i, op1_i, op2_i  in  XLEN each  payload from id
- rd_addr_i  in  RADDR_W  payload from id
- reg_wen_i  in  1  payload from id
- out_valid_o  out  1  output payload valid for ex
- out_ready_i  in  1  ex consumes the output payload this cycle
- inst_o, inst_addr_o, op1_o, op2_o  out  XLEN each  payload to ex
- rd_addr_o  out  RADDR_W  payload to ex
- reg_wen_o  out  1  payload to ex; forced 0 whenever out_valid_o=0

## Operation
- Storage: main register (drives outputs) plus skid register. State is EMPTY, ONE (main valid) or FULL (main and skid valid).
- acc = in_valid_i & in_ready_o; drn = out_valid_o & out_ready_i.
- in_ready_o = 1 in EMPTY and ONE, 0 in FULL. It is a registered decode of state, with no combinational path from out_ready_i.
- Bubble payload: inst=NOP_INST, inst_addr=0, op1=0, op2=0, rd_addr=0, reg_wen=0. Main holds the bubble whenever out_valid_o=0.
- Transitions when flush_i=0:
  - EMPTY, acc: main<=input, go to ONE. EMPTY, !acc: stay in EMPTY.
  - ONE, drn&acc: main<=input, stay in ONE.
  - ONE, drn&!acc: main<=bubble, go to EMPTY.
  - ONE, !drn&acc: skid<=input, go to FULL.
  - ONE, !drn&!acc: hold.
  - FULL, drn: main<=skid, skid cleared, go to ONE. FULL, !drn: hold.
- Flush takes priority over every other event. Next state is EMPTY, main<=bubble, skid cleared, and input payload is dropped even when acc=1.
- Reset: asynchronous to EMPTY. All outputs take bubble values, out_valid_o=0, in_ready_o=1. Reset mid-FULL loses both entries, with no partial update.
- Payload is never modified, merged or reordered. Order of acceptance equals order of presentation.

## Timing
- Latency: a payload accepted at edge N (EMPTY, or ONE while draining) appears on the outputs after edge N, i.e. in cycle N+1.
- Throughput: 1 payload/cycle sustained while out_ready_i=1.
- A single-cycle out_ready_i=0 in a stream loses no data and inserts no bubble. in_ready_o drops the cycle after the skid fills and rises the cycle after it drains.
- Outputs are stable while out_valid_o=1 and out_ready_i=0.
- flush_i at edge N gives out_valid_o=0 and in_ready_o=1 from cycle N+1.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle -> outputs immediately show inst_o=32'h13, other payload 0, out_valid_o=0, in_ready_o=1.
- Streaming: out_ready_i=1, present inst 0x100..0x10F with addr 0x0..0x3C on consecutive cycles -> each appears one cycle later, out_valid_o continuous, no gaps.
- Backpressure: stream A,B,C with out_ready_i=0 on the cycle after A is accepted.
  - A is held on the output, B goes to skid, in_ready_o=0, C is stalled at the input.
  - out_ready_i=1 -> outputs show A, then B, then C, none lost or duplicated.
- Flush in FULL: state with A on main and B in skid, flush_i=1 with C on input -> next cycle out_valid_o=0, inst_o=NOP_INST, in_ready_o=1. C, A and B are never seen at the output.
- Drain to bubble: single payload reg_wen_i=1, rd_addr_i=7, consumed with no follow-on -> next cycle reg_wen_o=0, rd_addr_o=0, inst_o=NOP_INST.
- Parameters: XLEN=64, RADDR_W=6, with the streaming and backpressure scenarios repeated -> full-width payload such as 64'hDEAD_BEEF_0000_0001 passes unchanged.
